// File: rtl/tpu_sequencer.sv
// Weight-load-and-compute pass sequencer for the systolic array top level.
// Define SEQ_WATCHDOG_EN to bound the WRITE phase and raise error on timeout.
module tpu_sequencer #(
    parameter int unsigned WIDTH_HEIGHT   = 16,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned COMPUTE_CYCLES = 19
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [7:0]                weight_base,
    input  logic                      fifo_done,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [WIDTH_HEIGHT-1:0]   weightMem_rd_en,
    output logic [WIDTH_HEIGHT*8-1:0] weightMem_rd_addr,
    output logic                      load_weights_to_array,
    output logic [WIDTH_HEIGHT-1:0]   weight_write,
    output logic                      active
);

    localparam int unsigned ROW_W   = (WIDTH_HEIGHT > 1) ? $clog2(WIDTH_HEIGHT) : 1;
    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > COMPUTE_CYCLES) ? SETTLE_CYCLES : COMPUTE_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DRAIN, S_WRITE, S_COMPUTE, S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ROW_W-1:0]   r_row;
    logic [ROW_W-1:0]   w_row_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_base;
    logic [7:0]         w_base_nxt;
    logic [7:0]         w_addr_nxt;

    logic                      r_busy, w_busy;
    logic                      r_done, w_done;
    logic [WIDTH_HEIGHT-1:0]   r_rd_en, w_rd_en;
    logic [WIDTH_HEIGHT*8-1:0] r_rd_addr, w_rd_addr;
    logic                      r_load, w_load;
    logic [WIDTH_HEIGHT-1:0]   r_wwrite, w_wwrite;
    logic                      r_active, w_active;

`ifdef SEQ_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(2 * WIDTH_HEIGHT);
    logic [WD_W-1:0] r_wd;
    logic            r_error;
    logic            w_wd_expire;

    assign w_wd_expire = (r_state == S_WRITE) && (r_wd == WD_W'(2 * WIDTH_HEIGHT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd    <= '0;
            r_error <= 1'b0;
        end else begin
            r_wd <= (r_state == S_WRITE) ? r_wd + WD_W'(1) : '0;
            if (r_state == S_IDLE && start)
                r_error <= 1'b0;
            else if (w_wd_expire && !fifo_done)
                r_error <= 1'b1;
        end
    end

    assign error = r_error;
`else
    assign error = 1'b0;
`endif

    // State register and phase counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_row   <= '0;
            r_cnt   <= '0;
            r_base  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            if (r_state == S_IDLE && start)
                r_base <= weight_base;
            if ((r_state == S_DRAIN || r_state == S_COMPUTE) && w_state_nxt == r_state)
                r_cnt <= r_cnt + CNT_W'(1);
            else
                r_cnt <= '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start) w_state_nxt = S_FETCH;
            S_FETCH:   if (r_row == ROW_W'(WIDTH_HEIGHT - 1)) w_state_nxt = S_DRAIN;
            S_DRAIN:   if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) w_state_nxt = S_WRITE;
            S_WRITE: begin
                if (fifo_done)
                    w_state_nxt = S_COMPUTE;
`ifdef SEQ_WATCHDOG_EN
                else if (w_wd_expire)
                    w_state_nxt = S_DONE;
`endif
            end
            S_COMPUTE: if (r_cnt == CNT_W'(COMPUTE_CYCLES - 1)) w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the flops line up with the state they describe
    always_comb begin
        w_row_nxt  = (r_state == S_FETCH) ? r_row + ROW_W'(1) : '0;
        w_base_nxt = (r_state == S_IDLE) ? weight_base : r_base;
        w_addr_nxt = w_base_nxt + 8'(w_row_nxt);
        w_busy     = (w_state_nxt == S_FETCH) || (w_state_nxt == S_DRAIN) ||
                     (w_state_nxt == S_WRITE) || (w_state_nxt == S_COMPUTE);
        w_done     = (w_state_nxt == S_DONE);
        w_rd_en    = (w_state_nxt == S_FETCH) ? '1 : '0;
        w_rd_addr  = (w_state_nxt == S_FETCH) ? {WIDTH_HEIGHT{w_addr_nxt}} : r_rd_addr;
        w_load     = (w_state_nxt == S_FETCH) || (w_state_nxt == S_WRITE);
        w_wwrite   = (w_state_nxt == S_WRITE) ? '1 : '0;
        w_active   = (w_state_nxt == S_COMPUTE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_en   <= '0;
            r_rd_addr <= '0;
            r_load    <= 1'b0;
            r_wwrite  <= '0;
            r_active  <= 1'b0;
        end else begin
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_rd_en   <= w_rd_en;
            r_rd_addr <= w_rd_addr;
            r_load    <= w_load;
            r_wwrite  <= w_wwrite;
            r_active  <= w_active;
        end
    end

    assign busy                  = r_busy;
    assign done                  = r_done;
    assign weightMem_rd_en       = r_rd_en;
    assign weightMem_rd_addr     = r_rd_addr;
    assign load_weights_to_array = r_load;
    assign weight_write          = r_wwrite;
    assign active                = r_active;

endmodule

// File: tb/tb_tpu_sequencer.sv
// Directed table-driven bench for tpu_sequencer: per-segment inputs and expected phase outputs.
module tb_tpu_sequencer;

    localparam int unsigned WH = 16;
    localparam int unsigned SC = 16;
    localparam int unsigned CC = 19;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        weight_base;
    logic              fifo_done;
    logic              busy, done, error;
    logic [WH-1:0]     weightMem_rd_en;
    logic [WH*8-1:0]   weightMem_rd_addr;
    logic              load_weights_to_array;
    logic [WH-1:0]     weight_write;
    logic              active;

    always #5 clk = ~clk;

    tpu_sequencer #(
        .WIDTH_HEIGHT  (WH),
        .SETTLE_CYCLES (SC),
        .COMPUTE_CYCLES(CC)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .start                (start),
        .weight_base          (weight_base),
        .fifo_done            (fifo_done),
        .busy                 (busy),
        .done                 (done),
        .error                (error),
        .weightMem_rd_en      (weightMem_rd_en),
        .weightMem_rd_addr    (weightMem_rd_addr),
        .load_weights_to_array(load_weights_to_array),
        .weight_write         (weight_write),
        .active               (active)
    );

    typedef enum {P_ID, P_FE, P_DR, P_WR, P_CO, P_DN} ph_t;

    typedef struct {
        bit         st;
        bit         fd;
        logic [7:0] base;
        int         n;
        ph_t        ph;
        logic [7:0] addr;
        bit         inc;
        bit         err;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input bit st, input bit fd, input logic [7:0] b, input int n,
                       input ph_t ph, input logic [7:0] a, input bit inc, input bit err);
        vec_t v;
        v.st = st; v.fd = fd; v.base = b; v.n = n;
        v.ph = ph; v.addr = a; v.inc = inc; v.err = err;
        vecs.push_back(v);
    endtask

    // Expected {busy, done, rd_en, load, weight_write, active} for each phase
    function automatic logic [5:0] flags(input ph_t ph);
        case (ph)
            P_FE:    return 6'b101100;
            P_DR:    return 6'b100000;
            P_WR:    return 6'b100110;
            P_CO:    return 6'b100001;
            P_DN:    return 6'b010000;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic chk(input string name, input int v, input int c,
                       input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d cyc %0d got %h expected %h", name, v, c, act, exp);
        end
    endtask

    task automatic check_state(input ph_t ph, input logic [7:0] a, input bit err,
                               input int v, input int c);
        logic [5:0] f;
        f = flags(ph);
        chk("busy",   v, c, 128'(busy),                  128'(f[5]));
        chk("done",   v, c, 128'(done),                  128'(f[4]));
        chk("rd_en",  v, c, 128'(weightMem_rd_en),       128'({WH{f[3]}}));
        chk("load",   v, c, 128'(load_weights_to_array), 128'(f[2]));
        chk("wwrite", v, c, 128'(weight_write),          128'({WH{f[1]}}));
        chk("active", v, c, 128'(active),                128'(f[0]));
        chk("rd_addr",v, c, 128'(weightMem_rd_addr),     128'({WH{a}}));
        chk("error",  v, c, 128'(error),                 128'(err));
    endtask

    task automatic run(input int lo, input int hi);
        logic [7:0] a;
        for (int v = lo; v < hi; v++) begin
            for (int c = 0; c < vecs[v].n; c++) begin
                start       = vecs[v].st;
                fifo_done   = vecs[v].fd;
                weight_base = vecs[v].base;
                @(posedge clk);
                #1;
                a = vecs[v].inc ? vecs[v].addr + 8'(c) : vecs[v].addr;
                check_state(vecs[v].ph, a, vecs[v].err, v, c);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n1, n2;
        // Pass 1: nominal, base 0x00, fifo_done on WRITE cycle 16
        add(1, 0, 8'h00,  1, P_FE, 8'h00, 1, 0);
        add(0, 0, 8'h00, 15, P_FE, 8'h01, 1, 0);
        add(0, 0, 8'h00, 16, P_DR, 8'h0F, 0, 0);
        add(0, 0, 8'h00, 16, P_WR, 8'h0F, 0, 0);
        add(0, 1, 8'h00,  1, P_CO, 8'h0F, 0, 0);
        add(0, 0, 8'h00, 18, P_CO, 8'h0F, 0, 0);
        add(0, 0, 8'h00,  1, P_DN, 8'h0F, 0, 0);
        add(0, 0, 8'h00,  2, P_ID, 8'h0F, 0, 0);
        // Pass 2: wrap from 0xFA, fifo_done during FETCH and DRAIN ignored, early fifo_done
        add(1, 0, 8'hFA,  1, P_FE, 8'hFA, 1, 0);
        add(0, 1, 8'hFA,  4, P_FE, 8'hFB, 1, 0);
        add(0, 0, 8'hFA, 11, P_FE, 8'hFF, 1, 0);
        add(0, 0, 8'hFA, 16, P_DR, 8'h09, 0, 0);
        add(0, 1, 8'hFA,  1, P_WR, 8'h09, 0, 0);
        add(0, 1, 8'hFA,  1, P_CO, 8'h09, 0, 0);
        add(0, 0, 8'hFA, 18, P_CO, 8'h09, 0, 0);
        add(0, 0, 8'hFA,  1, P_DN, 8'h09, 0, 0);
        add(0, 0, 8'hFA,  1, P_ID, 8'h09, 0, 0);
        // Pass 3: start held high, base changes after capture, restart right after DONE
        add(1, 0, 8'h10,  1, P_FE, 8'h10, 1, 0);
        add(1, 0, 8'h77, 15, P_FE, 8'h11, 1, 0);
        add(1, 0, 8'h77, 16, P_DR, 8'h1F, 0, 0);
        add(1, 0, 8'h77,  3, P_WR, 8'h1F, 0, 0);
        add(1, 1, 8'h77,  1, P_CO, 8'h1F, 0, 0);
        add(1, 0, 8'h77, 18, P_CO, 8'h1F, 0, 0);
        add(1, 0, 8'h77,  1, P_DN, 8'h1F, 0, 0);
        add(1, 0, 8'h77,  1, P_ID, 8'h1F, 0, 0);
        add(1, 0, 8'h33,  1, P_FE, 8'h33, 1, 0);
        add(0, 0, 8'h33,  4, P_FE, 8'h34, 1, 0);
        n1 = vecs.size();
        // Pass 4: full pass from row 0 after a mid-FETCH reset
        add(1, 0, 8'h40,  1, P_FE, 8'h40, 1, 0);
        add(0, 0, 8'h40, 15, P_FE, 8'h41, 1, 0);
        add(0, 0, 8'h40, 16, P_DR, 8'h4F, 0, 0);
        add(0, 0, 8'h40,  2, P_WR, 8'h4F, 0, 0);
        add(0, 1, 8'h40,  1, P_CO, 8'h4F, 0, 0);
        add(0, 0, 8'h40, 18, P_CO, 8'h4F, 0, 0);
        add(0, 0, 8'h40,  1, P_DN, 8'h4F, 0, 0);
        add(0, 0, 8'h40,  1, P_ID, 8'h4F, 0, 0);
        // WRITE without fifo_done
        add(1, 0, 8'h00,  1, P_FE, 8'h00, 1, 0);
        add(0, 0, 8'h00, 15, P_FE, 8'h01, 1, 0);
        add(0, 0, 8'h00, 16, P_DR, 8'h0F, 0, 0);
`ifdef SEQ_WATCHDOG_EN
        add(0, 0, 8'h00, 32, P_WR, 8'h0F, 0, 0);
        add(0, 0, 8'h00,  1, P_DN, 8'h0F, 0, 1);
        add(0, 0, 8'h00,  2, P_ID, 8'h0F, 0, 1);
        add(1, 0, 8'h20,  1, P_FE, 8'h20, 1, 0);
`else
        add(0, 0, 8'h00, 100, P_WR, 8'h0F, 0, 0);
`endif
        n2 = vecs.size();

        reset = 1'b1; start = 1'b0; fifo_done = 1'b0; weight_base = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_state(P_ID, 8'h00, 1'b0, -1, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_state(P_ID, 8'h00, 1'b0, -1, 1);

        run(0, n1);

        // Asynchronous reset mid-FETCH: outputs clear without waiting for an edge
        start = 1'b0;
        reset = 1'b1;
        #1;
        check_state(P_ID, 8'h00, 1'b0, -2, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_state(P_ID, 8'h00, 1'b0, -2, i + 1);
        end
        reset = 1'b0;

        run(n1, n2);

        reset = 1'b1;
        #1;
        check_state(P_ID, 8'h00, 1'b0, -3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
